// File: rtl/spi_arbiter_if.sv
// Bus bundle between the SPI clients, the arbiter and the SPI peripheral.
interface spi_arbiter_if #(
    parameter int unsigned NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req;
    logic [16*NUM_REQ-1:0] req_data;
    logic [3*NUM_REQ-1:0]  req_ss;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    done;
    logic [7:0]            rd_data;
    logic                  busy;
    logic [15:0]           SPI_data;
    logic [2:0]            ss;
    logic                  wrt_SPI;
    logic                  SPI_done;
    logic [7:0]            EEP_data;
    logic                  timeout_err;

    modport slave (
        input  req, req_data, req_ss, SPI_done, EEP_data,
        output gnt, done, rd_data, busy, SPI_data, ss, wrt_SPI, timeout_err
    );

    modport master (
        output req, req_data, req_ss, SPI_done, EEP_data,
        input  gnt, done, rd_data, busy, SPI_data, ss, wrt_SPI, timeout_err
    );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ clients.
// Optional BUSY watchdog is compiled in with SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
    parameter int unsigned NUM_REQ     = 3
`ifdef SPI_ARB_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
    logic [NUM_REQ-1:0] done_q, done_nxt;
    logic [7:0]         rd_q, rd_nxt;
    logic               busy_q, busy_nxt;
    logic [15:0]        data_q, data_nxt;
    logic [2:0]         ss_q, ss_nxt;
    logic               wrt_q, wrt_nxt;
    logic               spi_done_ff;
    logic               spi_rise;
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    logic [15:0]        word   [NUM_REQ];
    logic [2:0]         sel_ss [NUM_REQ];

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] wd_cnt, wd_cnt_nxt;
    logic             to_q, to_nxt;
    logic             wd_hit;

    assign wd_hit = (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign word[g]   = bus.req_data[16*g +: 16];
        assign sel_ss[g] = bus.req_ss[3*g +: 3];
    end

    // A level left high from an earlier transfer never looks like a new edge
    assign spi_rise = bus.SPI_done & ~spi_done_ff;

    // First set request at or after ptr, wrapping around
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (!pick_vld && bus.req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = idx;
        gnt_nxt   = gnt_q;
        done_nxt  = '0;
        rd_nxt    = rd_q;
        busy_nxt  = busy_q;
        data_nxt  = data_q;
        ss_nxt    = ss_q;
        wrt_nxt   = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        wd_cnt_nxt = wd_cnt;
        to_nxt     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = LAUNCH;
                    idx_nxt   = pick_idx;
                    gnt_nxt   = NUM_REQ'(1) << pick_idx;
                    busy_nxt  = 1'b1;
                    data_nxt  = word[pick_idx];
                    ss_nxt    = sel_ss[pick_idx];
                end
            end
            LAUNCH: begin
                state_nxt = BUSY;
                wrt_nxt   = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                wd_cnt_nxt = '0;
`endif
            end
            BUSY: begin
                if (spi_rise) begin
                    state_nxt = DONE;
                    done_nxt  = gnt_q;
                    rd_nxt    = bus.EEP_data;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (wd_hit) begin
                    state_nxt = DONE;
                    done_nxt  = gnt_q;
                    rd_nxt    = 8'hFF;
                    to_nxt    = 1'b1;
                end else begin
                    wd_cnt_nxt = wd_cnt + CNT_W'(1);
                end
`endif
            end
            DONE: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
                ptr_nxt   = (32'(idx) == NUM_REQ - 1) ? '0 : idx + IDX_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            idx         <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            rd_q        <= '0;
            busy_q      <= 1'b0;
            data_q      <= '0;
            ss_q        <= '0;
            wrt_q       <= 1'b0;
            spi_done_ff <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            idx         <= idx_nxt;
            gnt_q       <= gnt_nxt;
            done_q      <= done_nxt;
            rd_q        <= rd_nxt;
            busy_q      <= busy_nxt;
            data_q      <= data_nxt;
            ss_q        <= ss_nxt;
            wrt_q       <= wrt_nxt;
            spi_done_ff <= bus.SPI_done;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            to_q   <= 1'b0;
        end else begin
            wd_cnt <= wd_cnt_nxt;
            to_q   <= to_nxt;
        end
    end

    assign bus.timeout_err = to_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.rd_data  = rd_q;
    assign bus.busy     = busy_q;
    assign bus.SPI_data = data_q;
    assign bus.ss       = ss_q;
    assign bus.wrt_SPI  = wrt_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: expected grants/words/MISO bytes are queued
// as requests are planned and popped as each SPI launch and completion appears.
module tb_spi_arbiter;
    logic clk;
    logic rst_n;

    spi_arbiter_if #(.NUM_REQ(3)) bus ();

    spi_arbiter #(
        .NUM_REQ(3)
`ifdef SPI_ARB_TIMEOUT_EN
       ,.TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int          idx;
        logic [15:0] data;
        logic [2:0]  ss;
        logic [7:0]  miso;
    } txn_t;

    txn_t        exp_q[$];
    logic [15:0] wd [3];
    logic [2:0]  sv [3];
    int          mptr;
    int          total;
    int          bad;
    int          exp_wrt;
    int          wrt_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.wrt_SPI === 1'b1) wrt_seen++;

    initial begin
        #200000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [2:0] r, input int p);
        for (int k = 0; k < 3; k++) begin
            if (r[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    task automatic load();
        for (int i = 0; i < 3; i++) begin
            bus.req_data[16*i +: 16] = wd[i];
            bus.req_ss[3*i +: 3]     = sv[i];
        end
    endtask

    // Push the next n expected transactions for a given request pattern
    task automatic plan(input logic [2:0] r, input int n);
        txn_t e;
        for (int j = 0; j < n; j++) begin
            e.idx  = rr_pick(r, mptr);
            e.data = wd[e.idx];
            e.ss   = sv[e.idx];
            e.miso = 8'($urandom);
            exp_q.push_back(e);
            mptr = (e.idx + 1) % 3;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wrt(input string tag);
        int n;
        n = 0;
        while (bus.wrt_SPI !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.wrt_SPI), 32'd1);
    endtask

    // Act as the SPI peripheral for one launched transfer and score it
    task automatic serve(input logic [2:0] req_after, input bit hold);
        txn_t e;
        int   gap;
        wait_wrt("wrt_wait");
        bus.req = req_after;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        exp_wrt++;
        check("gnt", 32'(bus.gnt), 32'(3'b001 << e.idx));
        check("spi_data", 32'(bus.SPI_data), 32'(e.data));
        check("ss", 32'(bus.ss), 32'(e.ss));
        check("busy", 32'(bus.busy), 32'd1);
        tick();
        check("wrt_pulse", 32'(bus.wrt_SPI), 32'd0);
        if (bus.SPI_done === 1'b1) begin
            for (int j = 0; j < 3; j++) begin
                tick();
                check("stale_done", 32'(bus.done), 32'd0);
            end
            bus.SPI_done = 1'b0;
            tick();
        end
        gap = int'($urandom_range(0, 3));
        for (int j = 0; j < gap; j++) tick();
        bus.EEP_data = e.miso;
        bus.SPI_done = 1'b1;
        tick();
        check("done", 32'(bus.done), 32'(3'b001 << e.idx));
        check("rd_data", 32'(bus.rd_data), 32'(e.miso));
        check("timeout_err", 32'(bus.timeout_err), 32'd0);
        if (!hold) bus.SPI_done = 1'b0;
        bus.EEP_data = ~e.miso;
        tick();
        check("done_pulse", 32'(bus.done), 32'd0);
        check("idle_gnt", 32'(bus.gnt), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("rd_hold", 32'(bus.rd_data), 32'(e.miso));
        check("data_hold", 32'(bus.SPI_data), 32'(e.data));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_rd"}, 32'(bus.rd_data), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_data"}, 32'(bus.SPI_data), 32'd0);
        check({tag, "_ss"}, 32'(bus.ss), 32'd0);
        check({tag, "_wrt"}, 32'(bus.wrt_SPI), 32'd0);
        check({tag, "_to"}, 32'(bus.timeout_err), 32'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        exp_wrt  = 0;
        wrt_seen = 0;
        mptr     = 0;
        rst_n    = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_ss   = '0;
        bus.SPI_done = 1'b0;
        bus.EEP_data = '0;
        for (int i = 0; i < 3; i++) begin
            wd[i] = 16'h1111 * 16'(i + 1);
            sv[i] = 3'(i + 4);
        end
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Single requester with the exact latency sequence
        wd[1] = 16'hA5C3;
        sv[1] = 3'b010;
        load();
        plan(3'b010, 1);
        exp_q[0].miso = 8'h3C;
        bus.req = 3'b010;
        tick();
        check("lat_gnt", 32'(bus.gnt), 32'b010);
        check("lat_busy", 32'(bus.busy), 32'd1);
        check("lat_data", 32'(bus.SPI_data), 32'hA5C3);
        check("lat_ss", 32'(bus.ss), 32'b010);
        check("lat_wrt0", 32'(bus.wrt_SPI), 32'd0);
        tick();
        check("lat_wrt1", 32'(bus.wrt_SPI), 32'd1);
        serve(3'b000, 1'b0);

        // Simultaneous 0 and 2 after a fresh reset: 0 first, then 2
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mptr = 0;
        wd[0] = 16'hBEEF; sv[0] = 3'b001;
        wd[2] = 16'h0F0F; sv[2] = 3'b100;
        load();
        plan(3'b101, 2);
        bus.req = 3'b101;
        serve(3'b101, 1'b0);
        serve(3'b000, 1'b0);

        // Fairness with all three held
        for (int i = 0; i < 3; i++) begin
            wd[i] = 16'($urandom);
            sv[i] = 3'($urandom);
        end
        load();
        plan(3'b111, 6);
        bus.req = 3'b111;
        for (int t = 0; t < 5; t++) serve(3'b111, 1'b0);
        serve(3'b000, 1'b0);

        // SPI_done left high across DONE must not complete the next transfer
        plan(3'b010, 1);
        plan(3'b001, 1);
        bus.req = 3'b010;
        serve(3'b001, 1'b1);
        serve(3'b000, 1'b0);

        // Reset in the middle of BUSY abandons the transfer
        bus.req = 3'b010;
        wait_wrt("rst_wrt");
        exp_wrt++;
        bus.req = 3'b000;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        bus.EEP_data = 8'h77;
        bus.SPI_done = 1'b1;
        tick();
        check("midrst_nodone", 32'(bus.done), 32'd0);
        bus.SPI_done = 1'b0;
        tick();
        rst_n = 1'b1;
        mptr = 0;
        tick();
        check("postrst_nodone", 32'(bus.done), 32'd0);
        plan(3'b100, 1);
        bus.req = 3'b100;
        serve(3'b000, 1'b0);

`ifdef SPI_ARB_TIMEOUT_EN
        // Watchdog: SPI_done never rises
        begin
            int widx;
            widx = rr_pick(3'b001, mptr);
            mptr = (widx + 1) % 3;
            bus.req = 3'b001;
            wait_wrt("wd_wrt");
            exp_wrt++;
            bus.req = 3'b000;
            for (int j = 0; j < 15; j++) begin
                tick();
                check("wd_early", 32'(bus.done), 32'd0);
            end
            tick();
            check("wd_done", 32'(bus.done), 32'(3'b001 << widx));
            check("wd_err", 32'(bus.timeout_err), 32'd1);
            check("wd_rd", 32'(bus.rd_data), 32'hFF);
            tick();
            check("wd_err_pulse", 32'(bus.timeout_err), 32'd0);
            check("wd_idle_gnt", 32'(bus.gnt), 32'd0);
        end
`endif

        repeat (3) tick();
        check("wrt_count", 32'(wrt_seen), 32'(exp_wrt));
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
